// File: rtl/store_buffer.sv
// store_buffer: in-order posted-write FIFO with load hazard detect; STORE_BUFFER_ADDR_MATCH_EN selects per-entry address matching
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_wmask,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic             ld_check_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_stall,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [29:0]   addr_q  [DEPTH];
  logic [31:0]   data_q  [DEPTH];
  logic [3:0]    wmask_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          enq, deq;
  assign empty     = count == '0;
  assign st_ready  = count != CNT_W'(DEPTH);
  assign mem_valid = !empty;
  assign enq       = st_valid && st_ready && |st_wmask;
  assign deq       = mem_valid && mem_ready;
  assign mem_addr  = empty ? '0 : {addr_q[rd_ptr], 2'b00};
  assign mem_wdata = empty ? '0 : data_q[rd_ptr];
  assign mem_wmask = empty ? '0 : wmask_q[rd_ptr];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq != deq) count <= enq ? count + 1'b1 : count - 1'b1;
    end
  end
  // storage is deliberately unreset; occupancy alone decides what is live
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr]  <= st_addr[31:2];
      data_q[wr_ptr]  <= st_data;
      wmask_q[wr_ptr] <= st_wmask;
    end
  end
`ifdef STORE_BUFFER_ADDR_MATCH_EN
  logic [DEPTH-1:0] hit;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PW-1:0] age;
    assign age    = PW'(i) - rd_ptr;
    assign hit[i] = (CNT_W'(age) < count) && (addr_q[i] == ld_addr[31:2]);
  end
  assign ld_stall = ld_check_valid && |hit;
  logic unused;
  assign unused = ^{st_addr[1:0], ld_addr[1:0]};
`else
  assign ld_stall = ld_check_valid && !empty;
  logic unused;
  assign unused = ^{st_addr[1:0], ld_addr};
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer, honours STORE_BUFFER_ADDR_MATCH_EN
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;
  logic clk = 0, resetn = 0;
  logic st_valid = 0, mem_ready = 0, ld_check_valid = 0;
  logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0;
  logic [3:0] st_wmask = 0;
  logic st_ready, mem_valid, ld_stall, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wmask;
  logic [CNT_W-1:0] count;
  ent_t exp_q[$];
  ent_t e;
  int tests = 0, fails = 0;
  store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_wmask(st_wmask),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .ld_check_valid(ld_check_valid),
    .ld_addr(ld_addr), .ld_stall(ld_stall), .empty(empty), .count(count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_valid = 1; st_addr = a; st_data = d; st_wmask = m;
    exp_q.push_back('{a: {a[31:2], 2'b00}, d: d, m: m});
  endtask
  task automatic test_reset();
    #3;
    tests++;
    if ({st_ready, mem_valid, ld_stall, empty} !== 4'b1001 || count !== '0) begin
      fails++; $display("FAIL reset_flags got rdy=%b mv=%b st=%b em=%b cnt=%0d want 1 0 0 1 0", st_ready, mem_valid, ld_stall, empty, count);
    end
    tests++;
    if ({mem_addr, mem_wdata, mem_wmask} !== '0) begin
      fails++; $display("FAIL reset_mem got %h %h %b want zeros", mem_addr, mem_wdata, mem_wmask);
    end
    @(negedge clk) resetn = 1;
    tick();
  endtask
  task automatic test_single();
    push(32'h1002, 32'h00AB0000, 4'b0100);
    tick();
    st_valid = 0;
    e = exp_q[0];
    tests++;
    if (mem_valid !== 1 || mem_addr !== 32'h1000 || mem_wdata !== 32'h00AB0000 || mem_wmask !== 4'b0100) begin
      fails++; $display("FAIL single_out got v=%b %h %h %b want 1 00001000 00ab0000 0100", mem_valid, mem_addr, mem_wdata, mem_wmask);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (mem_valid !== 1 || {mem_addr, mem_wdata, mem_wmask} !== {e.a, e.d, e.m}) begin
        fails++; $display("FAIL hold_stable cyc %0d got %h %h %b want %h %h %b", k, mem_addr, mem_wdata, mem_wmask, e.a, e.d, e.m);
      end
    end
    mem_ready = 1;
    void'(exp_q.pop_front());
    tick();
    mem_ready = 0;
    tests++;
    if (empty !== 1 || mem_valid !== 0) begin
      fails++; $display("FAIL single_drain got empty=%b mv=%b want 1 0", empty, mem_valid);
    end
  endtask
  task automatic test_fill();
    for (int k = 0; k < DEPTH; k++) begin
      push(32'h3000 + 32'(4 * k), 32'hA0 + 32'(k), 4'b1111 >> (k % 4));
      tick();
    end
    tests++;
    if (count !== CNT_W'(DEPTH) || st_ready !== 0) begin
      fails++; $display("FAIL full got cnt=%0d rdy=%b want %0d 0", count, st_ready, DEPTH);
    end
    st_valid = 1; st_addr = 32'h3F00; st_data = 32'hDEAD; st_wmask = 4'hF;
    tick();
    tests++;
    if (count !== CNT_W'(DEPTH)) begin
      fails++; $display("FAIL fifth_store got cnt=%0d want %0d", count, DEPTH);
    end
    mem_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      e = exp_q.pop_front();
      tests++;
      if (mem_valid !== 1 || {mem_addr, mem_wdata, mem_wmask} !== {e.a, e.d, e.m}) begin
        fails++; $display("FAIL drain_order %0d got %h %h %b want %h %h %b", k, mem_addr, mem_wdata, mem_wmask, e.a, e.d, e.m);
      end
      tick();
      if (k == 0) begin
        st_valid = 0;
        tests++;
        if (count !== CNT_W'(DEPTH - 1)) begin
          fails++; $display("FAIL no_full_bypass got cnt=%0d want %0d", count, DEPTH - 1);
        end
      end
    end
    mem_ready = 0;
    tests++;
    if (empty !== 1) begin
      fails++; $display("FAIL fill_empty got %b want 1", empty);
    end
  endtask
  task automatic test_back_to_back();
    mem_ready = 1;
    push(32'h5000, 32'h1000, 4'b0011);
    tick();
    for (int k = 1; k < 20; k++) begin
      e = exp_q.pop_front();
      tests++;
      if (count !== 1 || mem_valid !== 1 || {mem_addr, mem_wdata, mem_wmask} !== {e.a, e.d, e.m}) begin
        fails++; $display("FAIL stream %0d got cnt=%0d %h %h %b want 1 %h %h %b", k, count, mem_addr, mem_wdata, mem_wmask, e.a, e.d, e.m);
      end
      push(32'h5000 + 32'(4 * k), 32'h1000 + 32'($urandom_range(0, 255) << 8) + 32'(k), 4'(k % 15 + 1));
      tick();
    end
    st_valid = 0;
    e = exp_q.pop_front();
    tests++;
    if ({mem_addr, mem_wdata, mem_wmask} !== {e.a, e.d, e.m}) begin
      fails++; $display("FAIL stream_last got %h %h %b want %h %h %b", mem_addr, mem_wdata, mem_wmask, e.a, e.d, e.m);
    end
    tick();
    mem_ready = 0;
    tests++;
    if (empty !== 1 || count !== 0) begin
      fails++; $display("FAIL stream_empty got em=%b cnt=%0d want 1 0", empty, count);
    end
  endtask
  task automatic test_zero_mask();
    st_valid = 1; st_addr = 32'h7000; st_data = 32'h55; st_wmask = 4'b0000;
    #1;
    tests++;
    if (st_ready !== 1) begin
      fails++; $display("FAIL zero_mask_ready got %b want 1", st_ready);
    end
    tick();
    st_valid = 0;
    tests++;
    if (count !== 0 || mem_valid !== 0) begin
      fails++; $display("FAIL zero_mask_drop got cnt=%0d mv=%b want 0 0", count, mem_valid);
    end
  endtask
  task automatic test_hazard();
    logic far_exp;
`ifdef STORE_BUFFER_ADDR_MATCH_EN
    far_exp = 0;
`else
    far_exp = 1;
`endif
    push(32'h2004, 32'h77, 4'b0001);
    tick();
    st_valid = 0;
    ld_check_valid = 1; ld_addr = 32'h2006;
    #1;
    tests++;
    if (ld_stall !== 1) begin
      fails++; $display("FAIL hazard_same_word got %b want 1", ld_stall);
    end
    ld_addr = 32'h2008;
    #1;
    tests++;
    if (ld_stall !== far_exp) begin
      fails++; $display("FAIL hazard_other_word got %b want %b", ld_stall, far_exp);
    end
    st_valid = 1; st_addr = 32'h2008; st_data = 32'h88; st_wmask = 4'b0010;
    #1;
    tests++;
    if (ld_stall !== far_exp) begin
      fails++; $display("FAIL hazard_incoming_store got %b want %b", ld_stall, far_exp);
    end
    st_valid = 0; ld_check_valid = 0; ld_addr = 32'h2004;
    #1;
    tests++;
    if (ld_stall !== 0) begin
      fails++; $display("FAIL hazard_no_check got %b want 0", ld_stall);
    end
    ld_check_valid = 1; mem_ready = 1;
    #1;
    tests++;
    if (ld_stall !== 1) begin
      fails++; $display("FAIL hazard_dequeuing got %b want 1", ld_stall);
    end
    void'(exp_q.pop_front());
    tick();
    mem_ready = 0; ld_check_valid = 0;
  endtask
  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      push(32'h9000 + 32'(4 * k), 32'hC0 + 32'(k), 4'hF);
      tick();
    end
    st_valid = 0;
    tests++;
    if (mem_valid !== 1 || count !== 3) begin
      fails++; $display("FAIL pre_reset got mv=%b cnt=%0d want 1 3", mem_valid, count);
    end
    #1 resetn = 0;
    #1;
    exp_q.delete();
    tests++;
    if (mem_valid !== 0 || count !== 0 || empty !== 1 || st_ready !== 1 || mem_addr !== 0) begin
      fails++; $display("FAIL async_reset got mv=%b cnt=%0d em=%b rdy=%b addr=%h want 0 0 1 1 0", mem_valid, count, empty, st_ready, mem_addr);
    end
    @(negedge clk) resetn = 1;
    tick();
    push(32'hA000, 32'hFACE, 4'b1000);
    tick();
    st_valid = 0;
    e = exp_q.pop_front();
    tests++;
    if (count !== 1 || {mem_addr, mem_wdata, mem_wmask} !== {e.a, e.d, e.m}) begin
      fails++; $display("FAIL post_reset got cnt=%0d %h %h %b want 1 %h %h %b", count, mem_addr, mem_wdata, mem_wmask, e.a, e.d, e.m);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_zero_mask();
    test_hazard();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MEM-stage store alignment logic and the data-memory write port. The block accepts aligned store words with byte write masks, queues them in order, and drains them to memory over a valid/ready handshake. The pipeline can therefore retire stores without waiting on memory latency. The block also flags loads that would read a location with a store still pending, so the hazard unit can stall them.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH)+1, width of `count`

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- st_valid  in  1  aligned store request from MEM stage
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  32  byte address of the store; bits [1:0] are ignored
- st_data  in  32  aligned store data, already lane-positioned
- st_wmask  in  4  byte write mask, bit i enables byte lane i
- mem_valid  out  1  head entry is presented to memory
- mem_ready  in  1  memory accepts the head entry
- mem_addr  out  32  word address {head_addr[31:2], 2'b00}
- mem_wdata  out  32  head entry data
- mem_wmask  out  4  head entry mask
- ld_check_valid  in  1  a load in MEM is requesting a hazard check
- ld_addr  in  32  byte address of that load
- ld_stall  out  1  the load must wait
- empty  out  1  no entries are pending
- count  out  CNT_W  number of pending entries

## Operation
- Circular FIFO with write pointer, read pointer and occupancy counter. Storage per entry: addr[31:2], data[31:0], wmask[3:0].
- Enqueue fires when st_valid && st_ready && st_wmask != 0.
- A store with st_wmask == 0 is accepted but dropped: no entry is created and count is unchanged.
- st_ready = (count != DEPTH). A full buffer deasserts st_ready even if a drain occurs in the same cycle; there is no full-bypass.
- Dequeue fires when mem_valid && mem_ready, where mem_valid = !empty.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
- Handshake rule: while mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_wmask hold stable.
- Drain order is strictly in enqueue order. Entries are never merged or reordered.
- When empty=1, mem_addr, mem_wdata and mem_wmask are forced to 0.
- Pointers wrap modulo DEPTH.
- ld_stall is combinational. It is 0 whenever ld_check_valid=0. The comparison scope depends on the Configuration macro below.
- A store presented on st_* in the same cycle as a load check is not included in the comparison.
- The entry being dequeued in the current cycle is still included in the comparison.

## Timing
- Reset (resetn=0, asynchronous):
  - pointers and count are cleared to 0.
  - Outputs are: st_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wmask=0, ld_stall=0, empty=1, count=0.
  - Entry storage is not reset.
- Reset asserted mid-operation discards all pending entries immediately; no partial drain completes.
- Latency: a store enqueued at edge N is visible on mem_* with mem_valid=1 after edge N. There is no same-cycle pass-through.
- Throughput: one enqueue and one dequeue per cycle.
- count, empty and st_ready update on the edge after the handshake.

## Configuration
- STORE_BUFFER_ADDR_MATCH_EN defined:
  - ld_stall = ld_check_valid && (some valid entry has addr[31:2] == ld_addr[31:2]).
  - Uses one 30-bit comparator per entry.
- STORE_BUFFER_ADDR_MATCH_EN undefined:
  - Conservative check: ld_stall = ld_check_valid && !empty.
  - No comparators are built.

## Test plan
- Reset, then a single store with addr=0x1002, data=0x00AB0000, wmask=4'b0100:
  - Required: mem_valid=1 one cycle later, with mem_addr=0x1000, mem_wdata=0x00AB0000, mem_wmask=4'b0100.
  - Hold mem_ready=0 for 3 cycles: outputs stay stable.
  - Then mem_ready=1: empty=1 on the next cycle.
- Fill with DEPTH=4 stores while mem_ready=0:
  - Required: count=4 and st_ready=0.
  - A 5th st_valid is not accepted.
  - Then mem_ready=1 continuously: the 4 entries drain in order, 1 per cycle.
- Steady stream with st_valid=1 and mem_ready=1 every cycle for 20 cycles:
  - Required: count stays at 1 after the first cycle.
  - Data appears in order across pointer wrap.
- Store with wmask=4'b0000:
  - Required: st_ready=1, count stays 0, mem_valid stays 0.
- Load hazard, with an entry at 0x2004 pending and ld_check_valid=1:
  - ld_addr=0x2006 → ld_stall=1.
  - ld_addr=0x2008 → ld_stall=1 without the macro, 0 with it.
  - ld_check_valid=0 → ld_stall=0.
- Assert resetn=0 with 3 entries pending and mem_valid=1:
  - Required: mem_valid=0, count=0, empty=1, st_ready=1 immediately, without waiting for a clock edge.
